// File: rtl/pcm_pkg.sv
// Shared types and constants for the PCM A-law expansion path.
// Optional build macro used by this slice: PCM_EVEN_BIT_INVERT_EN.
package pcm_pkg;

  localparam int PCM_LOG_W = 8;
  localparam int PCM_LIN_W = 13;
  localparam logic [PCM_LOG_W-1:0] PCM_EVEN_MASK = 8'h55;

  typedef logic [PCM_LOG_W-1:0] pcm_log_t;
  typedef logic [PCM_LIN_W-1:0] pcm_lin_t;

  // Undo G.711 even-bit line inversion on a received log byte.
  function automatic pcm_log_t pcm_even_bit_restore(input pcm_log_t line_byte);
    return line_byte ^ PCM_EVEN_MASK;
  endfunction

endpackage

// File: rtl/pcm_alaw_expand.sv
// Purely combinational A-law log-to-linear expander.
// Output is 13-bit sign-magnitude: bit 12 sign, bits 11:0 magnitude.
// The segment shift is written out per segment so every result bit is explicit.
module pcm_alaw_expand
  import pcm_pkg::*;
(
  input  pcm_log_t log_i,
  output pcm_lin_t lin_o
);

  logic [3:0]  mant_s;
  logic [11:0] mag_s;

  assign mant_s = log_i[3:0];

  // Segment decode: segment 0 is linear, segments 1..7 double the step each time.
  always_comb begin
    mag_s = 12'h000;
    case (log_i[6:4])
      3'd0:    mag_s = {7'b0000000, mant_s, 1'b1};
      3'd1:    mag_s = {6'b000000, 1'b1, mant_s, 1'b1};
      3'd2:    mag_s = {5'b00000, 1'b1, mant_s, 1'b1, 1'b0};
      3'd3:    mag_s = {4'b0000, 1'b1, mant_s, 1'b1, 2'b00};
      3'd4:    mag_s = {3'b000, 1'b1, mant_s, 1'b1, 3'b000};
      3'd5:    mag_s = {2'b00, 1'b1, mant_s, 1'b1, 4'b0000};
      3'd6:    mag_s = {1'b0, 1'b1, mant_s, 1'b1, 5'b00000};
      3'd7:    mag_s = {1'b1, mant_s, 1'b1, 6'b000000};
      default: mag_s = 12'h000;
    endcase
  end

  assign lin_o = {log_i[7], mag_s};

endmodule

// File: rtl/pcm_expand_arbiter.sv
// Round-robin arbiter sharing one A-law expander between NUM_CH PCM channels.
// Stage 1 holds the accepted log byte and its channel, stage 2 holds the
// expanded linear sample; the output is tagged with the source channel.
// Build macro PCM_EVEN_BIT_INVERT_EN: when defined the accepted byte has its
// even bits restored (XOR 8'h55) before expansion; timing is unchanged.
module pcm_expand_arbiter
  import pcm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     in_valid,
  input  logic [8*NUM_CH-1:0]   in_data,
  output logic [NUM_CH-1:0]     in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PCM_LIN_W-1:0]  out_data,
  output logic [CH_W-1:0]       out_ch
);

  // Round-robin pointer
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;

  // Stage 1: log byte and channel
  logic              s1_valid_q, s1_valid_d;
  pcm_log_t          s1_log_q, s1_log_d;
  logic [CH_W-1:0]   s1_ch_q, s1_ch_d;

  // Stage 2: linear sample and channel (drives the outputs)
  logic              out_valid_q, out_valid_d;
  pcm_lin_t          out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;

  // Arbitration and flow control
  logic              grant_vld_s;
  logic [CH_W-1:0]   grant_ch_s;
  logic              s1_free_s;
  logic              s2_free_s;
  logic              s1_accept_s;
  logic              s2_load_s;
  logic [NUM_CH-1:0] in_ready_s;

  // Expander interface
  pcm_log_t          exp_in_s;
  pcm_lin_t          exp_out_s;

  // A stage can take new data when empty or when its content leaves this cycle.
  assign s2_free_s   = !out_valid_q || out_ready;
  assign s1_free_s   = !s1_valid_q || s2_free_s;
  assign s1_accept_s = grant_vld_s && s1_free_s;
  assign s2_load_s   = s1_valid_q && s2_free_s;

  // Round-robin search: first valid channel starting at the pointer, with wrap.
  always_comb begin
    logic [CH_W:0] idx_v;
    logic [CH_W:0] cand_v;
    logic          hit_v;
    grant_vld_s = 1'b0;
    grant_ch_s  = {CH_W{1'b0}};
    idx_v       = {(CH_W+1){1'b0}};
    cand_v      = {(CH_W+1){1'b0}};
    hit_v       = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx_v       = {1'b0, rr_ptr_q} + (CH_W+1)'(k);
      cand_v      = (idx_v >= (CH_W+1)'(NUM_CH)) ? (idx_v - (CH_W+1)'(NUM_CH)) : idx_v;
      hit_v       = !grant_vld_s && in_valid[cand_v[CH_W-1:0]];
      grant_ch_s  = hit_v ? cand_v[CH_W-1:0] : grant_ch_s;
      grant_vld_s = grant_vld_s || hit_v;
    end
  end

  // One-hot accept towards the granted channel, only when stage 1 can take it.
  always_comb begin
    in_ready_s = {NUM_CH{1'b0}};
    if (s1_accept_s) begin
      in_ready_s[grant_ch_s] = 1'b1;
    end else begin
      in_ready_s = {NUM_CH{1'b0}};
    end
  end

  assign in_ready = in_ready_s;

  // Pointer moves past the winner only on an accepted transfer.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (s1_accept_s) begin
      rr_ptr_d = (grant_ch_s == CH_W'(NUM_CH - 1)) ? {CH_W{1'b0}} : (grant_ch_s + CH_W'(1));
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Stage 1 next state: load on accept, empty when drained into stage 2.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_log_d   = s1_log_q;
    s1_ch_d    = s1_ch_q;
    if (s1_accept_s) begin
      s1_valid_d = 1'b1;
      s1_log_d   = in_data[8*grant_ch_s +: 8];
      s1_ch_d    = grant_ch_s;
    end else if (s2_load_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Line-coding restore ahead of the expander.
  always_comb begin
`ifdef PCM_EVEN_BIT_INVERT_EN
    exp_in_s = pcm_even_bit_restore(s1_log_q);
`else
    exp_in_s = s1_log_q;
`endif
  end

  pcm_alaw_expand u_expand (
    .log_i (exp_in_s),
    .lin_o (exp_out_s)
  );

  // Stage 2 next state: load expander result, drop valid once consumed.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (s2_load_s) begin
      out_valid_d = 1'b1;
      out_data_d  = exp_out_s;
      out_ch_d    = s1_ch_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline and pointer registers; reset flushes both stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= {CH_W{1'b0}};
      s1_valid_q  <= 1'b0;
      s1_log_q    <= {PCM_LOG_W{1'b0}};
      s1_ch_q     <= {CH_W{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {PCM_LIN_W{1'b0}};
      out_ch_q    <= {CH_W{1'b0}};
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_log_q    <= s1_log_d;
      s1_ch_q     <= s1_ch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_pcm_expand_arbiter.sv
// Directed self-checking bench for pcm_expand_arbiter (NUM_CH = 4).
// Expected values are hand-computed for both settings of PCM_EVEN_BIT_INVERT_EN.
module tb_pcm_expand_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_data;
  logic [1:0]  out_ch;

  int n_tests = 0;
  int n_fail  = 0;

  // Stream stimulus shared with run_stream
  logic [7:0]  tx_b [4];
  logic [12:0] tx_e [4];
  int          tx_acc [4];

  // Expected expansions of bytes 8'h10, 8'h20, 8'h30, 8'h40 (channel 0..3 in fairness test)
`ifdef PCM_EVEN_BIT_INVERT_EN
  localparam logic [12:0] EXP_10 = 13'h0158;
  localparam logic [12:0] EXP_20 = 13'h0AC0;
  localparam logic [12:0] EXP_30 = 13'h0560;
  localparam logic [12:0] EXP_40 = 13'h002B;
`else
  localparam logic [12:0] EXP_10 = 13'h0021;
  localparam logic [12:0] EXP_20 = 13'h0042;
  localparam logic [12:0] EXP_30 = 13'h0084;
  localparam logic [12:0] EXP_40 = 13'h0108;
`endif

  pcm_expand_arbiter #(.NUM_CH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 4'b0000;
    in_data   = 32'h0000_0000;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Stream n bytes from tx_b on channel ch with out_ready=1; check data, tag, latency.
  task automatic run_stream(input int ch, input int n);
    int idx = 0;
    int no  = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (idx < n) begin
        in_valid = 4'(1 << ch);
        in_data  = 32'(tx_b[idx]) << (8 * ch);
      end else begin
        in_valid = 4'b0000;
      end
      #1;
      if (out_valid) begin
        if (no < n) begin
          check_eq("stream_data", 32'(out_data), 32'(tx_e[no]));
          check_eq("stream_ch", 32'(out_ch), 32'(ch));
          check_eq("stream_latency", 32'(c - tx_acc[no]), 32'd2);
        end else begin
          check_eq("stream_extra_out", 32'd1, 32'd0);
        end
        no++;
      end
      if ((in_valid & in_ready) != 4'b0000) begin
        tx_acc[idx] = c;
        idx++;
      end
      if (idx >= n && no >= n) break;
    end
    check_eq("stream_count", 32'(no), 32'(n));
    in_valid = 4'b0000;
  endtask

  initial begin
    logic [12:0] fair_e [4];
    logic [12:0] bp_e [3];
    logic [7:0]  bp_b [3];
    int idx;
    int n_out;

    fair_e = '{EXP_10, EXP_20, EXP_30, EXP_40};
    bp_e   = '{EXP_10, EXP_20, EXP_30};
    bp_b   = '{8'h10, 8'h20, 8'h30};

    // ---- reset state ----
    do_reset();
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_out_ch", 32'(out_ch), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);

    // ---- single channel stream on ch0 ----
    tx_b = '{8'h00, 8'h35, 8'hFF, 8'h00};
`ifdef PCM_EVEN_BIT_INVERT_EN
    tx_e = '{13'h02B0, 13'h0420, 13'h106A, 13'h0000};
`else
    tx_e = '{13'h0001, 13'h00AC, 13'h1FC0, 13'h0000};
`endif
    run_stream(0, 3);

    // ---- fairness: all channels valid ----
    do_reset();
    in_data = 32'h4030_2010;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 4'b1111;
      #1;
      check_eq("fair_grant", 32'(in_ready), 32'(1 << (k % 4)));
      if (k >= 2) begin
        check_eq("fair_out_valid", 32'(out_valid), 32'd1);
        check_eq("fair_out_ch", 32'(out_ch), 32'((k - 2) % 4));
        check_eq("fair_out_data", 32'(out_data), 32'(fair_e[(k - 2) % 4]));
      end
    end
    in_valid = 4'b0000;

    // ---- backpressure: ch2 streams while out_ready is low for 5 cycles ----
    do_reset();
    idx   = 0;
    n_out = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      if (idx < 3) begin
        in_valid = 4'b0100;
        in_data  = {8'h00, bp_b[idx], 16'h0000};
      end else begin
        in_valid = 4'b0000;
      end
      #1;
      if (out_valid && out_ready) begin
        if (n_out < 3) check_eq("bp_out_data", 32'(out_data), 32'(bp_e[n_out]));
        else check_eq("bp_extra_out", 32'd1, 32'd0);
        n_out++;
      end
      if (c == 4) begin
        check_eq("bp_accepted", 32'(idx), 32'd2);
        check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
        check_eq("bp_hold_data", 32'(out_data), 32'(EXP_10));
      end
      if ((in_valid & in_ready) != 4'b0000) idx++;
      if (n_out >= 3 && idx >= 3) break;
    end
    check_eq("bp_out_count", 32'(n_out), 32'd3);
    @(negedge clk);
    #1;
    check_eq("bp_no_dup", 32'(out_valid), 32'd0);

    // ---- pointer wrap: ch3 then ch0 ----
    do_reset();
    in_data = 32'h4030_2010;
    @(negedge clk);
    in_valid = 4'b1000;
    #1;
    check_eq("wrap_grant3", 32'(in_ready), 32'b1000);
    @(negedge clk);
    in_valid = 4'b1001;
    #1;
    check_eq("wrap_grant0", 32'(in_ready), 32'b0001);
    @(negedge clk);
    in_valid = 4'b1001;
    #1;
    check_eq("wrap_ptr1_grant3", 32'(in_ready), 32'b1000);
    check_eq("wrap_out_ch3", 32'(out_ch), 32'd3);
    @(negedge clk);
    in_valid = 4'b0000;
    #1;
    check_eq("wrap_out_ch0", 32'(out_ch), 32'd0);

    // ---- asynchronous reset with both stages full ----
    do_reset();
    out_ready = 1'b0;
    in_data   = 32'h4030_2010;
    in_valid  = 4'b0010;
    repeat (3) @(negedge clk);
    #1;
    check_eq("mid_full_valid", 32'(out_valid), 32'd1);
    check_eq("mid_full_ready", 32'(in_ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_async_drop", 32'(out_valid), 32'd0);
    in_valid = 4'b0000;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b1111;
    #1;
    check_eq("mid_first_grant", 32'(in_ready), 32'b0001);
    check_eq("mid_flushed", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check_eq("mid_post_ch", 32'(out_ch), 32'd0);
    check_eq("mid_post_data", 32'(out_data), 32'(EXP_10));
    in_valid = 4'b0000;

    // ---- line-coding bytes on ch1 ----
    do_reset();
    tx_b = '{8'hD5, 8'h55, 8'h00, 8'h00};
`ifdef PCM_EVEN_BIT_INVERT_EN
    tx_e = '{13'h1001, 13'h0001, 13'h0000, 13'h0000};
`else
    tx_e = '{13'h12B0, 13'h02B0, 13'h0000, 13'h0000};
`endif
    run_stream(1, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
